// File: rtl/pack_arb_pkg.sv
// pack_arb_pkg: shared constants and FSM encoding for pack_arbiter
package pack_arb_pkg;
  localparam int DW = 24;
  localparam int BEATS_PER_GROUP = 16;
  localparam int WORDS_PER_GROUP = 3;
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
endpackage

// File: rtl/pack_arbiter_rr_pick.sv
// rr_pick: finds the first set request at or after ptr, wrapping to 0
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             found,
  output logic [IDW-1:0]   idx
);
  logic [N_REQ-1:0] rot;
  assign rot = N_REQ'({req, req} >> ptr);
  // descending scan so the lowest offset from ptr is the last (winning) write
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        idx = IDW'((int'(ptr) + k) % N_REQ);
      end
  end
endmodule

// File: rtl/pack_arbiter.sv
// pack_arbiter: grants one source per 16-beat packing group and tags packer output words
module pack_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW = pack_arb_pkg::DW,
  parameter int BEATS = pack_arb_pkg::BEATS_PER_GROUP,
  parameter int IDW = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                pk_valid_in,
  output logic [DW-1:0]       pk_data_in,
  input  logic                pk_valid_out,
  output logic                out_valid,
  output logic [IDW-1:0]      out_src,
  output logic                busy,
  output logic [IDW-1:0]      grant_id
);
  import pack_arb_pkg::*;
  localparam int CW = $clog2(BEATS);
  state_t state, state_n;
  logic [CW-1:0] beat_cnt;
  logic [IDW-1:0] rr_ptr, last_src, pick_idx;
  logic pick_found, accept, last_beat;
  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .found(pick_found),
    .idx(pick_idx)
  );
  assign busy = state == ST_BURST;
  assign accept = busy && req_valid[grant_id];
  assign last_beat = accept && beat_cnt == CW'(BEATS - 1);
  assign req_ready = busy ? N_REQ'(1) << grant_id : '0;
  assign pk_valid_in = accept;
  assign pk_data_in = accept ? req_data[grant_id*DW +: DW] : '0;
  // the IDLE bubble guarantees last_src is stable until the packer's final pulse
  assign out_valid = pk_valid_out;
  assign out_src = last_src;
  always_comb state_n = state == ST_IDLE ? (pick_found ? ST_BURST : ST_IDLE) : (last_beat ? ST_IDLE : ST_BURST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      beat_cnt <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
      last_src <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && pick_found) grant_id <= pick_idx;
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        last_src <= grant_id;
      end
      if (last_beat) rr_ptr <= grant_id == IDW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end
endmodule
